// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target with valid/ready request and response
// channels, byte-lane stores, programmable wait states and error flagging.
module dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;

  logic                  l_we;
  logic [31:0]           l_addr;
  logic [DATA_WIDTH-1:0] l_wdata;
  logic [3:0]            l_be;

  logic                  accept;
  logic                  commit;
  logic                  c_we;
  logic [31:0]           c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [3:0]            c_be;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic                  c_err;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // A zero-latency access commits on its accept edge, so it must see
  // the live request; otherwise the latched copy is used.
  assign c_we    = (state == IDLE) ? req_we    : l_we;
  assign c_addr  = (state == IDLE) ? req_addr  : l_addr;
  assign c_wdata = (state == IDLE) ? req_wdata : l_wdata;
  assign c_be    = (state == IDLE) ? req_be    : l_be;
  assign c_idx   = c_addr[ADDR_WIDTH+1:2];
  assign c_err   = (c_addr[1:0] != 2'b00) ||
                   ((c_addr >> (ADDR_WIDTH + 2)) != 32'd0);

  // Next-state, wait counter and commit strobe
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            commit   = 1'b1;
            state_nx = RESP;
          end else begin
            cnt_nx   = LAT4;
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          commit   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and wait-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Capture the request fields on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_we    <= 1'b0;
      l_addr  <= 32'd0;
      l_wdata <= '0;
      l_be    <= 4'd0;
    end else if (accept) begin
      l_we    <= req_we;
      l_addr  <= req_addr;
      l_wdata <= req_wdata;
      l_be    <= req_be;
    end
  end

  // Response fields change only at commit, so they hold through stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= c_err;
      rsp_rdata <= (c_err || c_we) ? '0 : mem[c_idx];
    end
  end

  // Byte-lane store; storage keeps its contents across reset
  always_ff @(posedge clk) begin
    if (commit && c_we && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a transaction-level reference
// model checked every cycle plus hand-computed literal expectations.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_responder #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_be(req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  initial begin
    assert (LAT >= 0 && LAT <= 15)
      else $fatal(1, "LATENCY outside 0..15");
  end

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  // Reference model: one transaction in flight, resolved after LAT edges
  logic [31:0] mm [1024];
  bit          m_busy = 0;
  bit          m_resp = 0;
  int          m_left = 0;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [31:0] exp_rd = 0;
  logic        exp_err = 0;

  function automatic void m_commit();
    bit e;
    int idx;
    e = (m_addr % 4 != 0) || (m_addr >= 32'd4096);
    idx = int'(m_addr / 4);
    exp_err = e;
    exp_rd = 32'd0;
    if (!e) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) mm[idx][8*b +: 8] = m_wdata[8*b +: 8];
      end else begin
        exp_rd = mm[idx];
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0;
      m_resp = 0;
      m_left = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1;
        m_we = req_we;
        m_addr = req_addr;
        m_wdata = req_wdata;
        m_be = req_be;
        m_left = LAT;
        if (LAT == 0) begin
          m_commit();
          m_resp = 1;
        end
      end
    end else if (!m_resp) begin
      m_left--;
      if (m_left == 0) begin
        m_commit();
        m_resp = 1;
      end
    end else if (rsp_ready) begin
      m_busy = 0;
      m_resp = 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
    end else begin
      chk("ready", {31'd0, req_ready}, {31'd0, !m_busy});
      chk("valid", {31'd0, rsp_valid}, {31'd0, m_resp});
      if (m_resp) begin
        chk("rdata", rsp_rdata, exp_rd);
        chk("err", {31'd0, rsp_err}, {31'd0, exp_err});
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    int n;
    n = 0;
    @(negedge clk);
    req_we = we;
    req_addr = a;
    req_wdata = wd;
    req_be = be;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic txn(input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     input int stall, input bit poke,
                     output logic [31:0] rd, output logic er,
                     output int lat);
    issue(we, a, wd, be);
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < stall; i++) begin
      if (poke && i == 1) begin
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 32'h10;
        req_wdata = 32'h0;
        req_be = 4'hF;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic start_hold(input logic we, input logic [31:0] a,
                            input logic [31:0] wd);
    int n;
    issue(we, a, wd, 4'hF);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic async_rst();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_ready", {31'd0, req_ready}, 32'd0);
    chk("arst_err", {31'd0, rsp_err}, 32'd0);
    chk("arst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("init_ready", {31'd0, req_ready}, 32'd1);

    txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, lat);
    chk("st_lat", lat, 32'd2);
    chk("st_err", {31'd0, er}, 32'd0);
    chk("st_rdata", rd, 32'd0);

    txn(0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat);
    chk("ld_lat", lat, 32'd2);
    chk("ld_rdata", rd, 32'hDEADBEEF);

    txn(1, 32'h10, 32'h11223344, 4'b0101, 0, 0, rd, er, lat);
    txn(0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat);
    chk("be_rdata", rd, 32'hDE22BE44);

    txn(0, 32'h12, 32'h0, 4'h0, 0, 0, rd, er, lat);
    chk("mis_err", {31'd0, er}, 32'd1);
    chk("mis_rdata", rd, 32'd0);

    txn(1, 32'h0, 32'h55AA55AA, 4'hF, 0, 0, rd, er, lat);
    txn(1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er, lat);
    chk("oor_err", {31'd0, er}, 32'd1);
    txn(0, 32'h0, 32'h0, 4'h0, 0, 0, rd, er, lat);
    chk("oor_word0", rd, 32'h55AA55AA);

    txn(1, 32'h10, 32'h99999999, 4'h0, 0, 0, rd, er, lat);
    chk("be0_err", {31'd0, er}, 32'd0);
    txn(0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat);
    chk("be0_keep", rd, 32'hDE22BE44);

    txn(0, 32'h10, 32'h0, 4'h0, 5, 1, rd, er, lat);
    chk("bp_rdata", rd, 32'hDE22BE44);
    txn(0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat);
    chk("bp_poke_ignored", rd, 32'hDE22BE44);

    txn(1, 32'h20, 32'h01020304, 4'hF, 0, 0, rd, er, lat);
    issue(1, 32'h20, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    txn(0, 32'h20, 32'h0, 4'h0, 0, 0, rd, er, lat);
    chk("busy_rst_keep", rd, 32'h01020304);

    start_hold(0, 32'h12, 32'h0);
    async_rst();

    start_hold(1, 32'h30, 32'hA5A50F0F);
    async_rst();
    txn(0, 32'h30, 32'h0, 4'h0, 0, 0, rd, er, lat);
    chk("resp_rst_keep", rd, 32'hA5A50F0F);
    chk("resp_rst_lat", lat, 32'd2);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
